// File: rtl/pwm_output.sv
`default_nettype none
// ============================================================================
// pwm_output : double-buffered 8-bit PWM audio output stage with sample requests.
// Optional macro PWM_RAMP_EN adds RAMP_UP/RAMP_DOWN gain states.   Rev 1.0
// ============================================================================
module pwm_output #(
    parameter int PRESCALE  = 1,
    parameter int RAMP_STEP = 16
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       en,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    output logic       sample_req,
    output logic       underrun,
    output logic       pwm_out,
    output logic       active
);
    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RUN       = 2'd1;
`ifdef PWM_RAMP_EN
    localparam logic [1:0] RAMP_UP   = 2'd2;
    localparam logic [1:0] RAMP_DOWN = 2'd3;
    localparam logic [8:0] STEP      = 9'(RAMP_STEP);
    localparam logic [8:0] UP_LAST   = 9'(256 - RAMP_STEP);
`endif

    if (PRESCALE < 1 || RAMP_STEP < 1 || RAMP_STEP > 256 ||
        (RAMP_STEP & (RAMP_STEP - 1)) != 0) begin : g_param_check
        $error("pwm_output: PRESCALE must be >= 1, RAMP_STEP a power of 2 <= 256");
    end

    logic [1:0]    state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [7:0]    cnt, cnt_n, hold, hold_n, duty, duty_n, cmp_n;
    logic          fresh, fresh_n, pwm_n, req_n, und_n;
    logic          tick, wrap, start, stop, load;
`ifdef PWM_RAMP_EN
    logic [8:0]    g, g_n;
`endif

    assign tick  = (state != IDLE) && (pre == PRE_LAST);
    assign wrap  = tick && (cnt == 8'hFF);
    assign start = (state == IDLE) && en;

    always_comb begin
        state_n = state;
        stop    = 1'b0;
`ifdef PWM_RAMP_EN
        g_n = g;
        case (state)
            IDLE: begin
                if (en) begin
                    state_n = RAMP_UP;
                    g_n     = '0;
                end
            end
            RAMP_UP: begin
                if (!en) begin
                    state_n = RAMP_DOWN;
                end else if (wrap) begin
                    if (g >= UP_LAST) begin
                        g_n     = 9'd256;
                        state_n = RUN;
                    end else begin
                        g_n = g + STEP;
                    end
                end
            end
            RUN: begin
                if (!en) state_n = RAMP_DOWN;
            end
            default: begin
                if (en) begin
                    state_n = RAMP_UP;
                end else if (wrap) begin
                    // Gain may already be below one step if the ramp was reversed early.
                    if (g <= STEP) begin
                        g_n     = '0;
                        state_n = IDLE;
                        stop    = 1'b1;
                    end else begin
                        g_n = g - STEP;
                    end
                end
            end
        endcase
`else
        case (state)
            IDLE: begin
                if (en) state_n = RUN;
            end
            default: begin
                if (!en) begin
                    state_n = IDLE;
                    stop    = 1'b1;
                end
            end
        endcase
`endif
    end

    // A wrap that coincides with stopping is suppressed: no pulses once idle.
    always_comb begin
        load    = start || (wrap && !stop);
        pre_n   = (state_n == IDLE || start || tick) ? '0 : pre + PW'(1);
        cnt_n   = (state_n == IDLE || start) ? 8'd0 : (tick ? cnt + 8'd1 : cnt);
        duty_n  = load ? hold : duty;
        hold_n  = sample_valid ? sample : hold;
        fresh_n = sample_valid ? 1'b1 : (load ? 1'b0 : fresh);
        req_n   = load;
        und_n   = wrap && !stop && !fresh;
`ifdef PWM_RAMP_EN
        cmp_n   = 8'((17'(duty_n) * 17'(g_n)) >> 8);
`else
        cmp_n   = duty_n;
`endif
        pwm_n   = (state_n != IDLE) && (cnt_n < cmp_n);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            pre        <= '0;
            cnt        <= '0;
            hold       <= '0;
            duty       <= '0;
            fresh      <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            pwm_out    <= 1'b0;
`ifdef PWM_RAMP_EN
            g          <= '0;
`endif
        end else begin
            state      <= state_n;
            pre        <= pre_n;
            cnt        <= cnt_n;
            hold       <= hold_n;
            duty       <= duty_n;
            fresh      <= fresh_n;
            sample_req <= req_n;
            underrun   <= und_n;
            pwm_out    <= pwm_n;
`ifdef PWM_RAMP_EN
            g          <= g_n;
`endif
        end
    end

    assign active = (state != IDLE);

endmodule
`default_nettype wire
